// File: rtl/seq_101.sv
// rtl/seq_101.sv - overlapping 1-0-1 serial pattern detector
// Moore FSM; o_ strobe is decoded from the state register only, so it never glitches on in.
module seq_101 (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_1    = 2'd1;
  localparam logic [1:0] S_10   = 2'd2;
  localparam logic [1:0] S_101  = 2'd3;

  logic [1:0] r_state;
  logic [1:0] w_next;

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = in ? S_1   : S_IDLE;
      S_1:     w_next = in ? S_1   : S_10;
      S_10:    w_next = in ? S_101 : S_IDLE;
      // trailing 1 of a match seeds the next candidate
      S_101:   w_next = in ? S_1   : S_10;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  assign out = (r_state == S_101);

endmodule

// File: tb/tb_seq_101.sv
// tb/tb_seq_101.sv - self-checking bench for seq_101
// Reference: out is high when the last three bits since reset read 1,0,1.
module tb_seq_101;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in  = 1'b0;
  logic out;

  seq_101 dut (
    .clk(clk),
    .rst(rst),
    .in (in),
    .out(out)
  );

  always #5 clk = ~clk;

  int         n_pass   = 0;
  int         n_total  = 0;
  logic [2:0] hist     = 3'b000;
  int         nbits    = 0;
  logic       prev_out = 1'b0;

  task automatic step(input logic b, input logic r, input string tag);
    logic e;
    @(negedge clk);
    in  = b;
    rst = r;
    @(posedge clk);
    #1;
    if (r) begin
      nbits = 0;
    end else begin
      hist  = {hist[1:0], b};
      nbits = nbits + 1;
    end
    e = (nbits >= 3) && (hist == 3'b101);
    n_total++;
    assert (out === e) n_pass++;
    else $error("FAIL %s: out=%b expected=%b", tag, out, e);
    n_total++;
    assert (!(prev_out === 1'b1 && out === 1'b1)) n_pass++;
    else $error("FAIL %s_consec: out=%b prev=%b expected no back-to-back high", tag, out, prev_out);
    prev_out = out;
  endtask

  initial begin
    step(0, 1, "reset");
    step(1, 1, "reset_hold_in1");
    step(0, 1, "reset_hold_in0");
    step(1, 1, "reset_hold_in1b");

    step(1, 0, "basic_1");
    step(0, 0, "basic_0");
    step(1, 0, "basic_match");
    step(0, 0, "basic_after");

    step(0, 1, "rst_overlap");
    step(1, 0, "ovl_1");
    step(0, 0, "ovl_2");
    step(1, 0, "ovl_match1");
    step(0, 0, "ovl_4");
    step(1, 0, "ovl_match2");
    step(1, 0, "ovl_6");

    step(0, 1, "rst_nomatch");
    step(1, 0, "nm_1");
    step(1, 0, "nm_2");
    step(0, 0, "nm_3");
    step(0, 0, "nm_4");
    step(1, 0, "nm_5");
    step(0, 1, "rst_zeros");
    step(0, 0, "zero_1");
    step(0, 0, "zero_2");
    step(0, 0, "zero_3");

    step(0, 1, "rst_ones");
    step(1, 0, "ones_1");
    step(1, 0, "ones_2");
    step(1, 0, "ones_3");
    step(0, 0, "ones_4");
    step(1, 0, "ones_match");

    step(0, 1, "rst_mid");
    step(1, 0, "mid_1");
    step(0, 0, "mid_0");
    step(1, 1, "mid_reset");
    step(1, 0, "mid_after_1");
    step(0, 0, "mid_after_0");
    step(1, 0, "mid_match");

    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0), "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
